// File: rtl/kronos_dmem_arbiter.sv
// kronos_dmem_arbiter
// Two-master round-robin arbiter in front of a single data-memory port.
// Master 0 is the core LSU and master 1 is the debug/DMA path. One transfer
// is in flight at a time. A transfer ends on mem_ack, on a watchdog timeout
// that returns an error to the owner, or when the owner drops its request.
// Each transfer is followed by at least one idle cycle.
module kronos_dmem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstz,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wr_data,
    input  logic [3:0]  m0_mask,
    input  logic        m0_wr_en,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rd_data,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wr_data,
    input  logic [3:0]  m1_mask,
    input  logic        m1_wr_en,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rd_data,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_owner;       // 0 = master 0, 1 = master 1
    logic             r_last_grant;  // master that completed the last transfer
    logic [CNT_W-1:0] r_wait_cnt;    // BUSY cycles spent waiting for mem_ack

    logic        w_busy;
    logic        w_own_req;
    logic        w_own_wr_en;
    logic [31:0] w_own_addr;
    logic [31:0] w_own_wr_data;
    logic [3:0]  w_own_mask;
    logic        w_live;
    logic        w_timeout;
    logic        w_done;

    // Select the current owner's request and payload.
    assign w_busy        = (r_state == BUSY);
    assign w_own_req     = r_owner ? m1_req     : m0_req;
    assign w_own_wr_en   = r_owner ? m1_wr_en   : m0_wr_en;
    assign w_own_addr    = r_owner ? m1_addr    : m0_addr;
    assign w_own_wr_data = r_owner ? m1_wr_data : m0_wr_data;
    assign w_own_mask    = r_owner ? m1_mask    : m0_mask;

    // A transfer is live while the owner still holds its request. mem_ack
    // takes priority over the watchdog, so an ack on the last allowed cycle
    // completes normally without an error.
    assign w_live    = w_busy & w_own_req;
    assign w_timeout = w_live & ~mem_ack & (r_wait_cnt == CNT_LAST);
    assign w_done    = w_live & (mem_ack | w_timeout);

    // Memory side: payload follows the owner in BUSY and is zero in IDLE.
    // The request is withdrawn on the abort cycle.
    assign mem_req     = w_live & ~w_timeout;
    assign mem_wr_en   = w_live & w_own_wr_en;
    assign mem_addr    = w_busy ? w_own_addr    : 32'd0;
    assign mem_wr_data = w_busy ? w_own_wr_data : 32'd0;
    assign mem_mask    = w_busy ? w_own_mask    : 4'd0;

    // Master side: only the owner sees ack/err. Read data is broadcast and
    // only the acked master samples it.
    assign m0_ack     = w_done & ~r_owner;
    assign m1_ack     = w_done &  r_owner;
    assign m0_err     = w_timeout & ~r_owner;
    assign m1_err     = w_timeout &  r_owner;
    assign m0_rd_data = mem_rd_data;
    assign m1_rd_data = mem_rd_data;

    // Arbitration FSM: grant in IDLE, track completion/timeout/abandon in BUSY.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= '0;
                    if (m0_req && m1_req) begin
                        r_owner <= ~r_last_grant;
                        r_state <= BUSY;
                    end else if (m0_req) begin
                        r_owner <= 1'b0;
                        r_state <= BUSY;
                    end else if (m1_req) begin
                        r_owner <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_own_req) begin
                        // Owner abandoned the transfer; fairness state untouched.
                        r_wait_cnt <= '0;
                        r_state    <= IDLE;
                    end else if (w_done) begin
                        r_last_grant <= r_owner;
                        r_wait_cnt   <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_dmem_arbiter.sv
// Directed self-checking bench for kronos_dmem_arbiter (TIMEOUT = 64).
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge.
module tb_kronos_dmem_arbiter;

    logic        clk;
    logic        rstz;
    logic        m0_req, m0_wr_en, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wr_data, m0_rd_data;
    logic [3:0]  m0_mask;
    logic        m1_req, m1_wr_en, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wr_data, m1_rd_data;
    logic [3:0]  m1_mask;
    logic        mem_req, mem_wr_en, mem_ack;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic [3:0]  mem_mask;

    int n_vec = 0;
    int n_err = 0;

    kronos_dmem_arbiter #(.TIMEOUT(64)) dut (
        .clk(clk), .rstz(rstz),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_mask(m0_mask), .m0_wr_en(m0_wr_en), .m0_ack(m0_ack),
        .m0_err(m0_err), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_mask(m1_mask), .m1_wr_en(m1_wr_en), .m1_ack(m1_ack),
        .m1_err(m1_err), .m1_rd_data(m1_rd_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_mask(mem_mask), .mem_wr_en(mem_wr_en),
        .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic early;

        rstz = 1'b0;
        m0_req = 0; m0_addr = 0; m0_wr_data = 0; m0_mask = 0; m0_wr_en = 0;
        m1_req = 0; m1_addr = 0; m1_wr_data = 0; m1_mask = 0; m1_wr_en = 0;
        mem_ack = 0; mem_rd_data = 0;

        // Reset state
        sample();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        #1 rstz = 1'b1;
        step();

        // Single m0 load, ack on third busy cycle
        m0_req = 1; m0_addr = 32'h100; m0_mask = 4'hF; m0_wr_en = 0;
        sample();
        check("t1_lat_mem_req", mem_req, 0);
        step();
        sample();
        check("t1_c1_mem_req", mem_req, 1);
        check("t1_c1_mem_addr", mem_addr, 32'h100);
        check("t1_c1_wr_en", mem_wr_en, 0);
        check("t1_c1_ack", m0_ack, 0);
        step();
        sample();
        check("t1_c2_mem_req", mem_req, 1);
        step();
        mem_ack = 1; mem_rd_data = 32'hDEADBEEF;
        sample();
        check("t1_c3_mem_req", mem_req, 1);
        check("t1_c3_m0_ack", m0_ack, 1);
        check("t1_c3_m0_rd", m0_rd_data, 32'hDEADBEEF);
        check("t1_c3_m0_err", m0_err, 0);
        check("t1_c3_m1_ack", m1_ack, 0);
        step();
        m0_req = 0; mem_ack = 0;
        sample();
        check("t1_idle_mem_req", mem_req, 0);
        check("t1_idle_m0_ack", m0_ack, 0);

        // Fresh reset, then both masters contend and stay asserted
        rstz = 1'b0; #2 rstz = 1'b1;
        step();
        m0_req = 1; m0_addr = 32'hA0; m1_req = 1; m1_addr = 32'hB0;
        sample();
        check("t2_lat_mem_req", mem_req, 0);
        step();
        mem_ack = 1;
        sample();
        check("t2_g1_addr", mem_addr, 32'hA0);
        check("t2_g1_acks", {m1_ack, m0_ack}, 2'b01);
        step();
        mem_ack = 0;
        sample();
        check("t2_gap1_mem_req", mem_req, 0);
        check("t2_gap1_acks", {m1_ack, m0_ack}, 0);
        step();
        mem_ack = 1;
        sample();
        check("t2_g2_addr", mem_addr, 32'hB0);
        check("t2_g2_acks", {m1_ack, m0_ack}, 2'b10);
        step();
        mem_ack = 0;
        sample();
        check("t2_gap2_mem_req", mem_req, 0);
        step();
        mem_ack = 1;
        sample();
        check("t2_g3_addr", mem_addr, 32'hA0);
        check("t2_g3_acks", {m1_ack, m0_ack}, 2'b01);
        step();
        mem_ack = 0; m0_req = 0; m1_req = 0;
        sample();
        check("t2_end_mem_req", mem_req, 0);

        // m1 store that never gets acked: timeout on busy cycle 64
        step();
        m1_req = 1; m1_addr = 32'h200; m1_wr_data = 32'h12345678;
        m1_mask = 4'hF; m1_wr_en = 1;
        sample();
        check("t3_lat_mem_req", mem_req, 0);
        step();
        sample();
        check("t3_c1_mem_req", mem_req, 1);
        check("t3_c1_wr_en", mem_wr_en, 1);
        check("t3_c1_addr", mem_addr, 32'h200);
        check("t3_c1_wdata", mem_wr_data, 32'h12345678);
        check("t3_c1_mask", mem_mask, 4'hF);
        early = 1'b0;
        for (int i = 2; i <= 63; i++) begin
            step();
            sample();
            if (m1_ack || m1_err || m0_ack || m0_err) early = 1'b1;
        end
        check("t3_no_early_ack", early, 0);
        check("t3_c63_mem_req", mem_req, 1);
        step();
        sample();
        check("t3_to_m1_ack", m1_ack, 1);
        check("t3_to_m1_err", m1_err, 1);
        check("t3_to_mem_req", mem_req, 0);
        check("t3_to_m0", {m0_ack, m0_err}, 0);
        step();
        m1_req = 0; m1_wr_en = 0;
        sample();
        check("t3_idle_mem_req", mem_req, 0);
        check("t3_idle_m1", {m1_ack, m1_err}, 0);

        // m0 load acked on exactly the timeout cycle: normal completion
        step();
        m0_req = 1; m0_addr = 32'h300; m0_wr_en = 0;
        step();
        for (int i = 2; i <= 64; i++) step();
        mem_ack = 1; mem_rd_data = 32'hCAFEF00D;
        sample();
        check("t4_m0_ack", m0_ack, 1);
        check("t4_m0_err", m0_err, 0);
        check("t4_mem_req", mem_req, 1);
        check("t4_m0_rd", m0_rd_data, 32'hCAFEF00D);
        step();
        m0_req = 0; mem_ack = 0;
        sample();
        check("t4_idle_mem_req", mem_req, 0);

        // Reset asserted mid-transfer for m1
        step();
        m1_req = 1; m1_addr = 32'h400;
        step();
        sample();
        check("t5_busy_mem_req", mem_req, 1);
        #1 rstz = 1'b0;
        #1;
        check("t5_async_mem_req", mem_req, 0);
        check("t5_async_acks", {m0_ack, m1_ack}, 0);
        m0_req = 1; m0_addr = 32'h500; m1_addr = 32'h600;
        step();
        sample();
        #1 rstz = 1'b1;
        #1;
        check("t5_rel_mem_req", mem_req, 0);
        step();
        sample();
        check("t5_grant_mem_req", mem_req, 1);
        check("t5_grant_addr", mem_addr, 32'h500);
        step();
        mem_ack = 1;
        sample();
        check("t5_m0_ack", m0_ack, 1);

        // m1 granted then abandoned; stray idle ack ignored; fairness kept
        step();
        mem_ack = 0; m0_req = 0;
        sample();
        check("t6_idle_mem_req", mem_req, 0);
        step();
        m1_req = 0; mem_ack = 1;
        sample();
        check("t6_abandon_mem_req", mem_req, 0);
        check("t6_abandon_acks", {m0_ack, m1_ack}, 0);
        step();
        sample();
        check("t6_idle_ack_ignored", {m0_ack, m1_ack, mem_req}, 0);
        mem_ack = 0; m0_req = 1; m1_req = 1;
        step();
        sample();
        check("t6_rr_addr", mem_addr, 32'h600);
        step();
        mem_ack = 1;
        sample();
        check("t6_rr_acks", {m1_ack, m0_ack}, 2'b10);
        step();
        mem_ack = 0; m0_req = 0; m1_req = 0;
        sample();
        check("t6_end_mem_req", mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
